mcm_dp_engine: RTL and testbench
================================

// Module: mcm_dp_engine
// PURPOSE
//   Parametrised matrix-chain-order engine, successor to the fixed-size chain
//   multiplier top level. Dimensions p0..pN are loaded over a valid/ready
//   stream, then one FSM runs the O(N^3) dynamic program. Afterwards the host
//   reads the minimum cost m[i][j] and split point s[i][j] for any 1<=i<=j<=N.
//   Adds runtime chain length, an error flag, cost saturation and a
//   handshaked start/done that the earlier block does not have.
// PARAMETERS
//   MAX_N   16  maximum number of matrices in the chain (>=1)
//   DIM_W    8  width of one dimension value p_k
//   COST_W  32  width of a cost entry; arithmetic saturates at 2^COST_W-1
//   IDX_W    5  index width; must satisfy 2^IDX_W > MAX_N
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-low reset
//   dim_valid  in   1       dim_data is valid this cycle
//   dim_data   in   DIM_W   next dimension p_k, k = 0,1,2,...
//   dim_last   in   1       marks p_N, the final dimension
//   dim_ready  out  1       engine accepts a dimension (state LOAD)
//   start      in   1       1-cycle pulse that begins computation
//   busy       out  1       state CALC/WRITE
//   done       out  1       results valid; stays high until next load or reset
//   err        out  1       sticky load error; cleared by next accepted p0
//   num_mat    out  IDX_W   N of the loaded chain
//   rd_en      in   1       read request
//   rd_i,rd_j  in   IDX_W   table indices (1-based)
//   rd_valid   out  1       read data valid
//   rd_cost    out  COST_W  m[rd_i][rd_j]
//   rd_split   out  IDX_W   s[rd_i][rd_j]
// BEHAVIOUR
//   Reset (rst=0, async): state=LOAD, dim_ready=1, busy=done=err=rd_valid=0,
//     num_mat=0, rd_cost=rd_split=0. Table contents are undefined.
//   States: LOAD, READY, CALC, WRITE, DONE.
//   LOAD: a beat transfers when dim_valid&&dim_ready. Beat k stores p_k.
//     dim_last on beat k (k>=1): num_mat<=k, goto READY.
//     dim_last on beat 0 (N=0): err<=1, stay LOAD, restart at k=0.
//     Beat index reaching MAX_N+1 without dim_last: err<=1, discard to and
//     including the next dim_last beat, restart at k=0.
//   READY: start -> CALC, and m[i][i]<=0 for all i. start in any other
//     state is ignored.
//   CALC: loop l=2..N, i=1..N-l+1, j=i+l-1. One candidate k per cycle, for
//     k=i..j-1: c = m[i][k] + m[k+1][j] + p[i-1]*p[k]*p[j].
//     The product is 3*DIM_W wide and the sums are COST_W+2 wide; any result
//     above 2^COST_W-1 clamps to all-ones. Track the minimum with strict <,
//     so ties keep the smallest k.
//   WRITE (1 cycle): m[i][j]<=min, s[i][j]<=argmin, advance (i,l).
//     After the last pair, goto DONE.
//   Latency from start to done=1: 1 + sum over l=2..N of (N-l+1)*l cycles.
//     N=1 gives 1 cycle; N=3 gives 1+4+3 = 8 cycles.
//   DONE: done=1, dim_ready=1. The first accepted beat clears done and
//     re-enters LOAD as p0. start in DONE is ignored.
//   Read port: rd_en sampled only in DONE, otherwise ignored (rd_valid=0).
//     Data appears 1 cycle after rd_en, with rd_valid=1 for that cycle.
//     If i>j, i=0, or j>num_mat, returns rd_cost=0 and rd_split=0.
//     For i==j, returns cost 0 and split i.
//   Reset mid-CALC aborts immediately and the next run must reload.
//   dim_valid while busy is not accepted (dim_ready=0).
// TESTING
//   1 Load 10,30,5,60 (last on 60), start: done after 8 cycles;
//     m[1][3]=4500, s=2; m[1][2]=1500; m[2][3]=9000.
//   2 CLRS chain 30,35,15,5,10,20,25: m[1][6]=15125 s=3; m[2][5]=7125 s=3.
//   3 Load 7,9 (N=1): done 1 cycle after start; m[1][1]=0; rd_i=2 -> 0.
//   4 COST_W=16, load 255,255,255,255: m[1][3] saturates to 16'hFFFF,
//     and no wrap is visible.
//   5 Load MAX_N+2 beats without dim_last: err=1; then load 2,3,4: err clears
//     on p0; m[1][2]=24.
//   6 Drop rst mid-CALC: all outputs reach reset values immediately;
//     reload case 1 and start: results match case 1.

Source files
------------

// File: rtl/mcm_dp_engine.sv
// Matrix-chain-order engine: streams in p0..pN, runs the cubic
// dynamic program, then serves m[i][j] / s[i][j] over a read port.
module mcm_dp_engine #(
    parameter int MAX_N  = 16,
    parameter int DIM_W  = 8,
    parameter int COST_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dim_valid,
    input  logic [DIM_W-1:0]  dim_data,
    input  logic              dim_last,
    output logic              dim_ready,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDX_W-1:0]  num_mat,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_i,
    input  logic [IDX_W-1:0]  rd_j,
    output logic              rd_valid,
    output logic [COST_W-1:0] rd_cost,
    output logic [IDX_W-1:0]  rd_split
);

    localparam int PROD_W = 3 * DIM_W;
    localparam int SUM_W  = ((COST_W > PROD_W) ? COST_W : PROD_W) + 2;
    localparam int BEAT_W = IDX_W + 1;

    localparam logic [IDX_W-1:0]  ONE     = IDX_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_MX = BEAT_W'(MAX_N);
    localparam logic [BEAT_W-1:0] BEAT_OV = BEAT_W'(MAX_N + 1);

    typedef enum logic [2:0] {
        LOAD,
        READY,
        CALC,
        WRITE,
        DONE
    } state_t;

    state_t state;

    logic [BEAT_W-1:0] beat;
    logic              discard;
    logic [IDX_W-1:0]  l_r;
    logic [IDX_W-1:0]  i_r;
    logic [IDX_W-1:0]  k_r;
    logic [IDX_W-1:0]  arg_r;
    logic [COST_W-1:0] min_r;

    logic [DIM_W-1:0]  p_tab [0:MAX_N];
    logic [COST_W-1:0] m_tab [0:MAX_N][0:MAX_N];
    logic [IDX_W-1:0]  s_tab [0:MAX_N][0:MAX_N];

    logic [IDX_W-1:0]  j_c;
    logic [IDX_W-1:0]  im1_c;
    logic [IDX_W-1:0]  kp1_c;
    logic [SUM_W-1:0]  prod_c;
    logic [SUM_W-1:0]  sum_c;
    logic [COST_W-1:0] cand_c;
    logic              take_c;
    logic              load_we;
    logic              rd_bad;
    logic [COST_W-1:0] rd_cost_c;
    logic [IDX_W-1:0]  rd_split_c;

    assign j_c   = i_r + l_r - ONE;
    assign im1_c = i_r - ONE;
    assign kp1_c = k_r + ONE;

    // Beats past index MAX_N have no slot and are never stored.
    assign load_we = dim_valid && dim_ready && !discard
                     && (beat <= BEAT_MX);

    // Candidate cost for split k, clamped to the all-ones cost.
    always_comb begin
        prod_c = SUM_W'(p_tab[im1_c])
               * SUM_W'(p_tab[k_r])
               * SUM_W'(p_tab[j_c]);
        sum_c  = SUM_W'(m_tab[i_r][k_r])
               + SUM_W'(m_tab[kp1_c][j_c])
               + prod_c;
        if (|sum_c[SUM_W-1:COST_W]) begin
            cand_c = '1;
        end else begin
            cand_c = sum_c[COST_W-1:0];
        end
        // First k always loads so an all-saturated row still has an argmin.
        take_c = (k_r == i_r) || (cand_c < min_r);
    end

    // Read-port lookup with range checking and the trivial diagonal.
    always_comb begin
        rd_bad     = (rd_i == '0) || (rd_i > rd_j) || (rd_j > num_mat);
        rd_cost_c  = '0;
        rd_split_c = '0;
        if (!rd_bad) begin
            if (rd_i == rd_j) begin
                rd_split_c = rd_i;
            end else begin
                rd_cost_c  = m_tab[rd_i][rd_j];
                rd_split_c = s_tab[rd_i][rd_j];
            end
        end
    end

    // Dimension and result tables; contents are not reset.
    always_ff @(posedge clk) begin
        if (load_we) begin
            p_tab[beat[IDX_W-1:0]] <= dim_data;
        end
        if (state == READY && start) begin
            for (int d = 0; d <= MAX_N; d++) begin
                m_tab[IDX_W'(d)][IDX_W'(d)] <= '0;
            end
        end
        if (state == WRITE) begin
            m_tab[i_r][j_c] <= min_r;
            s_tab[i_r][j_c] <= arg_r;
        end
    end

    // Control FSM with registered handshake, status and read outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            beat      <= '0;
            discard   <= 1'b0;
            dim_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            num_mat   <= '0;
            l_r       <= '0;
            i_r       <= '0;
            k_r       <= '0;
            arg_r     <= '0;
            min_r     <= '0;
            rd_valid  <= 1'b0;
            rd_cost   <= '0;
            rd_split  <= '0;
        end else begin
            rd_valid <= 1'b0;
            unique case (state)
                LOAD, DONE: begin
                    if (state == DONE && rd_en) begin
                        rd_valid <= 1'b1;
                        rd_cost  <= rd_cost_c;
                        rd_split <= rd_split_c;
                    end
                    if (dim_valid) begin
                        state <= LOAD;
                        done  <= 1'b0;
                        if (discard) begin
                            if (dim_last) begin
                                discard <= 1'b0;
                                beat    <= '0;
                            end
                        end else if (beat == '0 && dim_last) begin
                            err <= 1'b1;
                        end else if (beat == BEAT_OV) begin
                            err     <= 1'b1;
                            beat    <= '0;
                            discard <= !dim_last;
                        end else if (dim_last) begin
                            num_mat   <= beat[IDX_W-1:0];
                            beat      <= '0;
                            dim_ready <= 1'b0;
                            state     <= READY;
                        end else begin
                            if (beat == '0) begin
                                err <= 1'b0;
                            end
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                READY: begin
                    if (start) begin
                        l_r <= IDX_W'(2);
                        i_r <= ONE;
                        k_r <= ONE;
                        if (num_mat == ONE) begin
                            done      <= 1'b1;
                            dim_ready <= 1'b1;
                            state     <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (take_c) begin
                        min_r <= cand_c;
                        arg_r <= k_r;
                    end
                    if (k_r == j_c - ONE) begin
                        state <= WRITE;
                    end else begin
                        k_r <= k_r + ONE;
                    end
                end
                WRITE: begin
                    if (i_r == num_mat - l_r + ONE) begin
                        if (l_r == num_mat) begin
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            dim_ready <= 1'b1;
                            state     <= DONE;
                        end else begin
                            l_r   <= l_r + ONE;
                            i_r   <= ONE;
                            k_r   <= ONE;
                            state <= CALC;
                        end
                    end else begin
                        i_r   <= i_r + ONE;
                        k_r   <= i_r + ONE;
                        state <= CALC;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcm_dp_engine.sv
// Bench for mcm_dp_engine: directed cases plus random chains
// checked against a textbook matrix-chain DP model.
module tb_mcm_dp_engine;

    localparam int MAX_N  = 16;
    localparam int DIM_W  = 8;
    localparam int COST_W = 32;
    localparam int IDX_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              dim_valid = 1'b0;
    logic [DIM_W-1:0]  dim_data = '0;
    logic              dim_last = 1'b0;
    logic              start = 1'b0;
    logic              rd_en = 1'b0;
    logic [IDX_W-1:0]  rd_i = '0;
    logic [IDX_W-1:0]  rd_j = '0;

    logic              dim_ready, busy, done, err, rd_valid;
    logic [IDX_W-1:0]  num_mat, rd_split;
    logic [COST_W-1:0] rd_cost;

    logic              d2_dim_ready, d2_busy, d2_done, d2_err, d2_rd_valid;
    logic [IDX_W-1:0]  d2_num_mat, d2_rd_split;
    logic [15:0]       d2_rd_cost;

    always #5 clk = ~clk;

    mcm_dp_engine #(
        .MAX_N(MAX_N), .DIM_W(DIM_W), .COST_W(COST_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst),
        .dim_valid(dim_valid), .dim_data(dim_data), .dim_last(dim_last),
        .dim_ready(dim_ready), .start(start), .busy(busy), .done(done),
        .err(err), .num_mat(num_mat), .rd_en(rd_en), .rd_i(rd_i),
        .rd_j(rd_j), .rd_valid(rd_valid), .rd_cost(rd_cost),
        .rd_split(rd_split)
    );

    mcm_dp_engine #(
        .MAX_N(MAX_N), .DIM_W(DIM_W), .COST_W(16), .IDX_W(IDX_W)
    ) dut16 (
        .clk(clk), .rst(rst),
        .dim_valid(dim_valid), .dim_data(dim_data), .dim_last(dim_last),
        .dim_ready(d2_dim_ready), .start(start), .busy(d2_busy),
        .done(d2_done), .err(d2_err), .num_mat(d2_num_mat),
        .rd_en(rd_en), .rd_i(rd_i), .rd_j(rd_j),
        .rd_valid(d2_rd_valid), .rd_cost(d2_rd_cost),
        .rd_split(d2_rd_split)
    );

    int checks = 0;
    int errors = 0;

    int     pv [0:MAX_N+1];
    longint rm [1:MAX_N][1:MAX_N];
    int     rs [1:MAX_N][1:MAX_N];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Textbook DP over pv[0..n], costs capped at 2^cw-1.
    task automatic model(input int n, input int cw);
        longint cap;
        longint v;
        int     b;
        cap = (64'sd1 <<< cw) - 1;
        for (int a = 1; a <= n; a++) begin
            rm[a][a] = 0;
            rs[a][a] = a;
        end
        for (int len = 2; len <= n; len++) begin
            for (int a = 1; a <= n - len + 1; a++) begin
                b = a + len - 1;
                rm[a][b] = -1;
                for (int c = a; c < b; c++) begin
                    v = rm[a][c] + rm[c+1][b]
                      + longint'(pv[a-1]) * pv[c] * pv[b];
                    if (v > cap) v = cap;
                    if (rm[a][b] < 0 || v < rm[a][b]) begin
                        rm[a][b] = v;
                        rs[a][b] = c;
                    end
                end
            end
        end
    endtask

    task automatic send(input int d, input logic last);
        int w;
        w = 0;
        while (!dim_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!dim_ready) chk("dim_ready_wait", dim_ready, 1);
        dim_valid = 1'b1;
        dim_data  = DIM_W'(d);
        dim_last  = last;
        @(negedge clk);
        dim_valid = 1'b0;
        dim_last  = 1'b0;
    endtask

    task automatic load_chain(input int n);
        for (int k = 0; k <= n; k++) send(pv[k], k == n);
    endtask

    task automatic run(input string tag, input int n);
        int cyc;
        int exp_lat;
        exp_lat = 1;
        for (int l = 2; l <= n; l++) exp_lat += (n - l + 1) * l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic read(input int i, input int j);
        rd_en = 1'b1;
        rd_i  = IDX_W'(i);
        rd_j  = IDX_W'(j);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int i, input int j,
                          input longint ec, input int es);
        read(i, j);
        chk({tag, "_valid"}, rd_valid, 1);
        chk({tag, "_cost"}, rd_cost, ec);
        chk({tag, "_split"}, rd_split, es);
    endtask

    task automatic check_all(input string tag, input int n);
        model(n, COST_W);
        for (int i = 1; i <= n; i++) begin
            for (int j = i; j <= n; j++) begin
                rd_chk($sformatf("%s_m%0d_%0d", tag, i, j), i, j,
                       rm[i][j], rs[i][j]);
            end
        end
        rd_chk({tag, "_rev"}, n, 1 + (n > 1 ? 0 : 1) - 1 + (n > 1 ? 0 : 0),
               (n > 1) ? 0 : 0, (n > 1) ? 0 : 1);
    endtask

    task automatic set_case1();
        pv[0] = 10; pv[1] = 30; pv[2] = 5; pv[3] = 60;
    endtask

    initial begin
        int n;

        // reset values
        @(negedge clk);
        chk("rst_dim_ready", dim_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_num_mat", num_mat, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_cost", rd_cost, 0);
        chk("rst_rd_split", rd_split, 0);
        rst = 1'b1;
        @(negedge clk);

        // case 1: 10,30,5,60
        set_case1();
        load_chain(3);
        chk("c1_num_mat", num_mat, 3);
        chk("c1_ready_low", dim_ready, 0);
        run("c1", 3);
        rd_chk("c1_m13", 1, 3, 4500, 2);
        rd_chk("c1_m12", 1, 2, 1500, 1);
        rd_chk("c1_m23", 2, 3, 9000, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("c1_start_in_done", done, 1);
        chk("c1_start_in_done_busy", busy, 0);

        // case 2: CLRS chain
        pv[0] = 30; pv[1] = 35; pv[2] = 15; pv[3] = 5;
        pv[4] = 10; pv[5] = 20; pv[6] = 25;
        load_chain(6);
        chk("c2_done_cleared", done, 0);
        run("c2", 6);
        rd_chk("c2_m16", 1, 6, 15125, 3);
        rd_chk("c2_m25", 2, 5, 7125, 3);
        check_all("c2", 6);

        // case 3: N=1 and read range checks
        pv[0] = 7; pv[1] = 9;
        load_chain(1);
        run("c3", 1);
        rd_chk("c3_m11", 1, 1, 0, 1);
        rd_chk("c3_rd_i2", 2, 1, 0, 0);
        rd_chk("c3_j_gt_n", 2, 2, 0, 0);
        rd_chk("c3_i0", 0, 1, 0, 0);

        // case 4: saturation on the 16-bit cost instance
        for (int k = 0; k <= 3; k++) pv[k] = 255;
        load_chain(3);
        run("c4", 3);
        model(3, 16);
        read(1, 3);
        chk("c4_sat_m13", d2_rd_cost, 16'hFFFF);
        chk("c4_sat_m13_model", d2_rd_cost, rm[1][3]);
        chk("c4_sat_s13", d2_rd_split, rs[1][3]);
        read(1, 2);
        chk("c4_sat_m12", d2_rd_cost, 16'hFFFF);
        check_all("c4_w32", 3);

        // N=0 load error
        send(5, 1'b1);
        chk("n0_err", err, 1);
        chk("n0_ready", dim_ready, 1);

        // case 5: overlong chain, discard, recover
        for (int k = 0; k <= MAX_N; k++) send(k + 1, 1'b0);
        chk("c5_no_err_at_max", err, 0);
        send(1, 1'b0);
        chk("c5_err", err, 1);
        send(1, 1'b0);
        send(1, 1'b1);
        chk("c5_err_held", err, 1);
        send(2, 1'b0);
        chk("c5_err_clr", err, 0);
        send(3, 1'b0);
        send(4, 1'b1);
        chk("c5_num_mat", num_mat, 2);
        run("c5", 2);
        rd_chk("c5_m12", 1, 2, 24, 1);

        // random chains, full MAX_N first
        for (int r = 0; r < 5; r++) begin
            n = (r == 0) ? MAX_N : int'($urandom_range(1, MAX_N));
            for (int k = 0; k <= n; k++) pv[k] = $urandom_range(0, 255);
            load_chain(n);
            chk($sformatf("rnd%0d_num_mat", r), num_mat, n);
            run($sformatf("rnd%0d", r), n);
            check_all($sformatf("rnd%0d", r), n);
        end

        // case 6: reset mid-computation
        set_case1();
        load_chain(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd_en = 1'b1;
        rd_i  = 1;
        rd_j  = 3;
        @(negedge clk);
        rd_en = 1'b0;
        chk("c6_busy", busy, 1);
        chk("c6_rd_ignored", rd_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("c6_rst_busy", busy, 0);
        chk("c6_rst_done", done, 0);
        chk("c6_rst_ready", dim_ready, 1);
        chk("c6_rst_num_mat", num_mat, 0);
        chk("c6_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load_chain(3);
        run("c6", 3);
        rd_chk("c6_m13", 1, 3, 4500, 2);
        rd_chk("c6_m12", 1, 2, 1500, 1);
        rd_chk("c6_m23", 2, 3, 9000, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
